// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants and FSM state encoding for the truth-table sequencer.
// States are plain logic constants so legacy tools without enum support can consume them.
package truth_table_sequencer_pkg;

    localparam int unsigned VEC_COUNT = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = 5;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSettle = 2'd1;
    localparam state_t StSample = 2'd2;
    localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// settle_timer: 4-bit loadable down-counter with a zero flag.
// The counter parks at zero; a load always wins over the decrement.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input function unit through all 16 vectors, samples f after a settle
// delay and compares against a latched golden truth table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    // The timer counts down to zero inclusive, so it is loaded with one less than the wait.
    localparam logic [3:0] SettleLoad = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam state_t     NextVecSt  = (SETTLE_CYCLES == 0) ? StSample : StSettle;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        exp_q, exp_d;
    logic [15:0]        result_q, result_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   first_fail_q, first_fail_d;
    logic               fail_valid_q, fail_valid_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;

    logic               timer_load;
    logic               timer_zero;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SettleLoad),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        exp_d        = exp_q;
        result_d     = result_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        timer_load   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    exp_d        = expected;
                    result_d     = 16'd0;
                    err_d        = '0;
                    first_fail_d = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
                    state_d      = NextVecSt;
                    timer_load   = 1'b1;
                end
            end

            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                end else if (timer_zero) begin
                    state_d = StSample;
                end
            end

            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    result_d[idx_q] = f;
                    if (f != exp_q[idx_q]) begin
                        if (err_q != CNT_W'(VEC_COUNT)) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (!fail_valid_q) begin
                            first_fail_d = idx_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(VEC_COUNT - 1)) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        state_d    = NextVecSt;
                        idx_d      = idx_q + IDX_W'(1);
                        timer_load = 1'b1;
                    end
                end
            end

            StDone: begin
                // done and pass register on the exit edge, landing 16*(SETTLE_CYCLES+1)+1
                // edges after the accepting edge.
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            exp_q        <= 16'd0;
            result_q     <= 16'd0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            exp_q        <= exp_d;
            result_q     <= result_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign a          = idx_q[3];
    assign b          = idx_q[2];
    assign c          = idx_q[1];
    assign d          = idx_q[0];
    assign busy       = (state_q == StSettle) || (state_q == StSample);
    assign done       = done_q;
    assign pass       = pass_q;
    assign result     = result_q;
    assign err_cnt    = err_q;
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: a table-driven function unit and a popcount/first-bit model of a sweep.
module tb_truth_table_sequencer;

    localparam int unsigned S   = 2;
    localparam int          VEC = 16 * (S + 1);
    localparam int          LAT = VEC + 1;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, f;
    logic        a, b, c, d, busy, done, pass, fail_valid;
    logic [15:0] expected, result, func_tbl;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Function unit under control: an arbitrary 16-entry truth table.
    assign f = func_tbl[{a, b, c, d}];

    truth_table_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .expected   (expected),
        .f          (f),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .result     (result),
        .err_cnt    (err_cnt),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    function automatic int popcnt(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int first_one(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One full sweep; with poke set, start pulses (and a changed expected) arrive mid-sweep and in DONE.
    task automatic run_sweep(input string name, input logic [15:0] func, input logic [15:0] gold,
                             input bit poke);
        int k;
        bit seen;
        int exp_idx;
        logic exp_busy;
        logic [15:0] mism;
        logic [15:0] held;
        func_tbl = func;
        expected = gold;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k <= LAT + 20) begin
            exp_busy = (k < VEC);
            exp_idx  = exp_busy ? k / (S + 1) : 0;
            n_tests++;
            if ({a, b, c, d} !== 4'(exp_idx) || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s vec k=%0d: abcd=%h busy=%b, want abcd=%h busy=%b",
                         name, k, {a, b, c, d}, busy, 4'(exp_idx), exp_busy);
            end
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (poke && (k == 5 || k == 20 || k == VEC)) begin
                    start    = 1'b1;
                    expected = ~gold;
                end else begin
                    start    = 1'b0;
                    expected = gold;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        start    = 1'b0;
        expected = gold;
        mism = func ^ gold;
        n_tests++;
        if (!seen || k != LAT) begin
            n_fail++;
            $display("FAIL %s latency: done seen=%0d at k=%0d, want k=%0d", name, seen, k, LAT);
        end
        n_tests++;
        if (result !== func || err_cnt !== 5'(popcnt(mism)) || fail_valid !== (mism != 0)
            || pass !== (mism == 0)) begin
            n_fail++;
            $display("FAIL %s outcome: result=%h err=%0d fv=%b pass=%b, want %h %0d %b %b",
                     name, result, err_cnt, fail_valid, pass, func, popcnt(mism), mism != 0,
                     mism == 0);
        end
        if (mism != 0) begin
            n_tests++;
            if (first_fail !== 4'(first_one(mism))) begin
                n_fail++;
                $display("FAIL %s first_fail: got %0d want %0d", name, first_fail, first_one(mism));
            end
        end
        held = result;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== func || pass !== (mism == 0)) begin
            n_fail++;
            $display("FAIL %s hold: done=%b busy=%b result=%h pass=%b, want 0 0 %h %b",
                     name, done, busy, result, pass, func, mism == 0);
        end
        if (held !== func) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s held result: got %h want %h", name, held, func);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({a, b, c, d, busy, done, pass, result, err_cnt, first_fail, fail_valid} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset: outputs=%h want 0",
                     {a, b, c, d, busy, done, pass, result, err_cnt, first_fail, fail_valid});
        end
    endtask

    task automatic test_xor_pass();
        run_sweep("xor_pass", 16'h6996, 16'h6996, 0);
    endtask

    task automatic test_single_mismatch();
        run_sweep("xor_6997", 16'h6996, 16'h6997, 0);
    endtask

    task automatic test_all_fail();
        run_sweep("all_fail", 16'h0000, 16'hFFFF, 0);
    endtask

    task automatic test_random();
        logic [15:0] fn;
        logic [15:0] gd;
        for (int i = 0; i < 6; i++) begin
            fn = 16'($urandom);
            gd = ($urandom_range(0, 2) == 0) ? fn : 16'($urandom);
            run_sweep($sformatf("random%0d", i), fn, gd, 0);
        end
    endtask

    task automatic test_back_to_back_start();
        run_sweep("start_ignored", 16'($urandom), 16'($urandom), 1);
    endtask

    task automatic test_abort();
        logic [15:0] fn;
        logic [15:0] gd;
        logic [15:0] mask;
        logic [15:0] mism;
        int n_done;
        fn = 16'($urandom) | 16'h0001;
        gd = 16'($urandom) & 16'hFFF0;
        func_tbl = fn;
        expected = gd;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        // Samples committed on edges (S+1)*(v+1) <= 10 survive the abort.
        mask = 16'((1 << (10 / (S + 1))) - 1);
        mism = (fn ^ gd) & mask;
        n_tests++;
        if (busy !== 1'b0 || {a, b, c, d} !== 4'd0 || pass !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort state: busy=%b abcd=%h pass=%b done=%b, want 0 0 0 0",
                     busy, {a, b, c, d}, pass, done);
        end
        n_tests++;
        if (result !== (fn & mask) || err_cnt !== 5'(popcnt(mism)) || fail_valid !== (mism != 0)
            || first_fail !== 4'(first_one(mism))) begin
            n_fail++;
            $display("FAIL abort partial: result=%h err=%0d fv=%b ff=%0d, want %h %0d %b %0d",
                     result, err_cnt, fail_valid, first_fail, fn & mask, popcnt(mism),
                     mism != 0, first_one(mism));
        end
        n_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort quiet: %0d cycles with done/busy, want 0", n_done);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n_act;
        func_tbl = 16'h6996;
        expected = 16'h0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({a, b, c, d, busy, done, pass, result, err_cnt, first_fail, fail_valid} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h want 0",
                     {a, b, c, d, busy, done, pass, result, err_cnt, first_fail, fail_valid});
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n_act = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) n_act++;
        end
        n_tests++;
        if (n_act != 0) begin
            n_fail++;
            $display("FAIL reset_mid quiet: %0d active cycles, want 0", n_act);
        end
    endtask

    task automatic test_start_abort_idle();
        int n_busy;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        n_busy = 0;
        repeat (4) begin
            if (busy !== 1'b0) n_busy++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (n_busy != 0) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy on %0d cycles, want 0", n_busy);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 16'd0;
        func_tbl = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_xor_pass();
        test_single_mismatch();
        test_all_fail();
        test_random();
        test_back_to_back_start();
        test_abort();
        test_reset_mid_sweep();
        test_start_abort_idle();
        test_xor_pass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
